lif_neuron_array: RTL and testbench
===================================

LIF_NEURON_ARRAY -- requirements
Module: lif_neuron_array

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of membrane, weight, leak, threshold and reset-value buses.
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent neurons (>=2).
REQ-003 SHALL have parameter REFRAC, default 3, refractory length in cycles (0 = none).
REQ-004 SHALL have parameter COUNT_W, default 16, width of the spike counter.
REQ-005 Port clk  input  1  single clock; all state updates on rising edge.
REQ-006 Port rst  input  1  reset, synchronous, active-high.
REQ-007 Port in_valid  input  1  qualifies one synaptic event this cycle.
REQ-008 Port in_ch  input  max(1,$clog2(CHANNELS))  target channel of the event.
REQ-009 Port in_weight  input  WIDTH  unsigned event magnitude.
REQ-010 Port in_inhib  input  1  1 = inhibitory (subtract), 0 = excitatory (add).
REQ-011 Port leak_tick  input  1  apply leak to all channels this cycle.
REQ-012 Port leak_amt  input  WIDTH  leak magnitude per tick.
REQ-013 Port thresh  input  WIDTH  firing threshold, shared by all channels.
REQ-014 Port v_reset  input  WIDTH  post-spike membrane value.
REQ-015 Port spike  output  CHANNELS  registered one-cycle spike pulse per channel.
REQ-016 Port membrane  output  CHANNELS*WIDTH  registered membrane values; channel c at bits [c*WIDTH +: WIDTH].
REQ-017 Port refrac_busy  output  CHANNELS  1 while channel's refractory counter is nonzero.
REQ-018 Port spike_count  output  COUNT_W  saturating total of spikes across all channels.

Function
REQ-019 Each channel SHALL evaluate per cycle in priority order: refractory, fire, integrate.
REQ-020 Refractory: if refrac_cnt[c]!=0, SHALL decrement it, hold membrane[c] at v_reset, drop any event to c, ignore leak, spike[c]=0.
REQ-021 Fire: else if membrane[c] > thresh (strict, unsigned, on registered value), SHALL set membrane[c]<=v_reset, refrac_cnt[c]<=REFRAC, spike[c]<=1 for exactly one cycle, and drop any event to c that cycle.
REQ-022 Integrate: else SHALL compute t = membrane[c] +/- in_weight when in_valid and in_ch==c, then t -= leak_amt when leak_tick; membrane[c]<=t.
REQ-023 Addition SHALL saturate at all-ones; every subtraction SHALL floor at 0 (no wrap).
REQ-024 Event and leak in the same cycle SHALL apply event first, then leak, each step saturated/floored independently.
REQ-025 in_ch >= CHANNELS SHALL be ignored with no state change.
REQ-026 Latency: event at edge k updates membrane after edge k; if result exceeds thresh, spike asserts after edge k+1.
REQ-027 spike SHALL deassert the cycle after assertion regardless of membrane value.
REQ-028 refrac_busy[c] SHALL equal (refrac_cnt[c]!=0); with REFRAC=0, a fired channel SHALL integrate the next cycle.
REQ-029 spike_count SHALL add popcount(next-cycle spike vector) each cycle, saturating at all-ones.
REQ-030 thresh, v_reset, leak_amt changes SHALL take effect on the next edge with no internal latching.

Reset
REQ-031 While rst=1 at an edge: membrane all 0, spike 0, refrac_busy 0, refractory counters 0, spike_count 0; rst SHALL override all other inputs, including mid-refractory and same-cycle fire.

Verification (WIDTH=8, CHANNELS=4, REFRAC=3, thresh=100, v_reset=0, leak_tick=0 unless stated)
REQ-032 Ch1 events +60, +60 -> membrane[1]=60 then 120; next cycle spike[1]=1, membrane[1]=0, refrac_busy[1]=1 for 3 cycles, spike_count=1.
REQ-033 thresh=255, ch0 +200 then +100 -> membrane[0]=255, no spike.
REQ-034 Ch2 at 30, inhibitory 50 -> membrane[2]=0; ch3 at 50, +40 with leak_tick, leak_amt=10 -> 80.
REQ-035 Ch1 event +90 during refractory -> dropped, membrane[1]=0 after refractory ends; in_ch=5 event (CHANNELS=4, 3-bit in_ch) -> no change.
REQ-036 Ch0 and ch2 both at 120 same cycle -> both spike same cycle, spike_count +2.
REQ-037 rst=1 during ch1 refractory with membrane[0]=80 -> all outputs 0 next cycle; first event after reset integrates normally.

Source files
------------

// File: rtl/lif_neuron_array.sv
// Array of leaky integrate-and-fire neurons sharing one synaptic event port.
// Per channel, each cycle: refractory hold, else fire, else integrate event
// then leak. Arithmetic saturates at all-ones and floors at zero.
module lif_neuron_array #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned REFRAC   = 3,
    parameter int unsigned COUNT_W  = 16,
    parameter int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [CH_W-1:0]             in_ch,
    input  logic [WIDTH-1:0]            in_weight,
    input  logic                        in_inhib,
    input  logic                        leak_tick,
    input  logic [WIDTH-1:0]            leak_amt,
    input  logic [WIDTH-1:0]            thresh,
    input  logic [WIDTH-1:0]            v_reset,
    output logic [CHANNELS-1:0]         spike,
    output logic [CHANNELS*WIDTH-1:0]   membrane,
    output logic [CHANNELS-1:0]         refrac_busy,
    output logic [COUNT_W-1:0]          spike_count
);

    localparam int unsigned RC_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic [RC_W-1:0] RC_LOAD = RC_W'(REFRAC);

    logic [WIDTH-1:0]    mem_q [CHANNELS];
    logic [WIDTH-1:0]    mem_d [CHANNELS];
    logic [RC_W-1:0]     rc_q  [CHANNELS];
    logic [RC_W-1:0]     rc_d  [CHANNELS];
    logic [CHANNELS-1:0] spike_q, spike_d;
    logic [COUNT_W-1:0]  count_q, count_d;

    logic                ch_ok;
    logic                hit;
    logic [WIDTH:0]      sum;
    logic [WIDTH-1:0]    t;
    logic [COUNT_W:0]    pop;
    logic [COUNT_W:0]    csum;

    // Per-channel next state: refractory > fire > integrate (event, then leak)
    always_comb begin
        ch_ok   = (32'(in_ch) < CHANNELS);
        hit     = 1'b0;
        sum     = '0;
        t       = '0;
        spike_d = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            mem_d[c] = mem_q[c];
            rc_d[c]  = rc_q[c];
            if (rc_q[c] != '0) begin
                rc_d[c]  = rc_q[c] - RC_W'(1);
                mem_d[c] = v_reset;
            end else if (mem_q[c] > thresh) begin
                rc_d[c]    = RC_LOAD;
                mem_d[c]   = v_reset;
                spike_d[c] = 1'b1;
            end else begin
                t   = mem_q[c];
                hit = in_valid && ch_ok && (32'(in_ch) == c);
                if (hit) begin
                    if (in_inhib) begin
                        t = (t > in_weight) ? (t - in_weight) : '0;
                    end else begin
                        sum = {1'b0, t} + {1'b0, in_weight};
                        t   = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
                    end
                end
                if (leak_tick) begin
                    t = (t > leak_amt) ? (t - leak_amt) : '0;
                end
                mem_d[c] = t;
            end
        end
    end

    // Saturating total of spikes issued next cycle
    always_comb begin
        pop = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            pop = pop + {{COUNT_W{1'b0}}, spike_d[c]};
        end
        csum    = {1'b0, count_q} + pop;
        count_d = csum[COUNT_W] ? '1 : csum[COUNT_W-1:0];
    end

    // State registers with synchronous reset overriding all inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                mem_q[c] <= '0;
                rc_q[c]  <= '0;
            end
            spike_q <= '0;
            count_q <= '0;
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                mem_q[c] <= mem_d[c];
                rc_q[c]  <= rc_d[c];
            end
            spike_q <= spike_d;
            count_q <= count_d;
        end
    end

    // Flatten registered state onto the output buses
    always_comb begin
        membrane    = '0;
        refrac_busy = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            membrane[c*WIDTH +: WIDTH] = mem_q[c];
            refrac_busy[c]             = (rc_q[c] != '0);
        end
    end

    assign spike       = spike_q;
    assign spike_count = count_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Self-checking bench for lif_neuron_array: directed scenarios followed by
// randomized traffic, all compared against an integer reference model.
module tb_lif_neuron_array;

    localparam int NCH = 4;
    localparam int RF  = 3;
    localparam int VMAX = 255;
    localparam int CMAX = 65535;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_inhib, leak_tick;
    logic [2:0]  in_ch;
    logic [7:0]  in_weight, leak_amt, thresh, v_reset;
    logic [3:0]  spike, refrac_busy;
    logic [31:0] membrane;
    logic [15:0] spike_count;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_mem [NCH];
    int m_rc  [NCH];
    int m_sp  [NCH];
    int m_cnt;

    lif_neuron_array #(
        .WIDTH(8), .CHANNELS(4), .REFRAC(3), .COUNT_W(16), .CH_W(3)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch),
        .in_weight(in_weight), .in_inhib(in_inhib), .leak_tick(leak_tick),
        .leak_amt(leak_amt), .thresh(thresh), .v_reset(v_reset),
        .spike(spike), .membrane(membrane), .refrac_busy(refrac_busy),
        .spike_count(spike_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One cycle of the neuron rules, evaluated on the inputs present before the edge
    task automatic model_step();
        int nm, fired, t;
        fired = 0;
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_mem[c] = 0; m_rc[c] = 0; m_sp[c] = 0;
            end
            m_cnt = 0;
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            if (m_rc[c] > 0) begin
                m_rc[c]--; nm = int'(v_reset); m_sp[c] = 0;
            end else if (m_mem[c] > int'(thresh)) begin
                m_rc[c] = RF; nm = int'(v_reset); m_sp[c] = 1; fired++;
            end else begin
                t = m_mem[c];
                if (in_valid && int'(in_ch) == c) begin
                    if (in_inhib) t = (t - int'(in_weight) < 0) ? 0 : t - int'(in_weight);
                    else          t = (t + int'(in_weight) > VMAX) ? VMAX : t + int'(in_weight);
                end
                if (leak_tick) t = (t - int'(leak_amt) < 0) ? 0 : t - int'(leak_amt);
                nm = t; m_sp[c] = 0;
            end
            m_mem[c] = nm;
        end
        m_cnt = (m_cnt + fired > CMAX) ? CMAX : m_cnt + fired;
    endtask

    task automatic compare_all();
        logic [3:0] esp, ebusy;
        for (int c = 0; c < NCH; c++) begin
            esp[c]   = m_sp[c][0];
            ebusy[c] = (m_rc[c] != 0);
            chk($sformatf("membrane[%0d]", c), 64'(membrane[c*8 +: 8]), 64'(m_mem[c]));
        end
        chk("spike", 64'(spike), 64'(esp));
        chk("refrac_busy", 64'(refrac_busy), 64'(ebusy));
        chk("spike_count", 64'(spike_count), 64'(m_cnt));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic ev(input int ch, input int w, input bit inh);
        in_valid = 1'b1; in_ch = 3'(ch); in_weight = 8'(w); in_inhib = inh;
        tick();
        in_valid = 1'b0; in_inhib = 1'b0;
    endtask

    initial begin
        int base;
        rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_weight = '0; in_inhib = 1'b0;
        leak_tick = 1'b0; leak_amt = '0; thresh = 8'd100; v_reset = 8'd0;
        for (int c = 0; c < NCH; c++) begin
            m_mem[c] = 0; m_rc[c] = 0; m_sp[c] = 0;
        end
        m_cnt = 0;
        @(negedge clk);
        tick(); tick();
        chk("reset_membrane", 64'(membrane), 64'd0);
        chk("reset_count", 64'(spike_count), 64'd0);
        rst = 1'b0;

        // two excitatory events cross threshold, fire, then refractory
        ev(1, 60, 0);
        chk("ch1_first", 64'(membrane[15:8]), 64'd60);
        ev(1, 60, 0);
        chk("ch1_second", 64'(membrane[15:8]), 64'd120);
        chk("no_early_spike", 64'(spike), 64'd0);
        tick();
        chk("ch1_spike", 64'(spike), 64'b0010);
        chk("ch1_reset_val", 64'(membrane[15:8]), 64'd0);
        chk("ch1_busy", 64'(refrac_busy), 64'b0010);
        chk("count_one", 64'(spike_count), 64'd1);
        // event during refractory is dropped
        ev(1, 90, 0);
        chk("spike_one_cycle", 64'(spike), 64'd0);
        chk("refrac_drop", 64'(membrane[15:8]), 64'd0);
        tick();
        chk("busy_third", 64'(refrac_busy[1]), 64'd1);
        tick();
        chk("busy_done", 64'(refrac_busy[1]), 64'd0);
        chk("after_refrac", 64'(membrane[15:8]), 64'd0);
        // out-of-range channel
        ev(5, 77, 0);
        chk("bad_ch", 64'(membrane), 64'd0);

        // saturation at all-ones with max threshold
        thresh = 8'd255;
        ev(0, 200, 0);
        ev(0, 100, 0);
        chk("sat_add", 64'(membrane[7:0]), 64'd255);
        tick();
        chk("sat_no_spike", 64'(spike), 64'd0);
        thresh = 8'd100;
        repeat (5) tick();

        // inhibitory floor, event then leak
        ev(2, 30, 0);
        ev(2, 50, 1);
        chk("inhib_floor", 64'(membrane[23:16]), 64'd0);
        ev(3, 50, 0);
        leak_tick = 1'b1; leak_amt = 8'd10;
        ev(3, 40, 0);
        leak_tick = 1'b0;
        chk("event_leak", 64'(membrane[31:24]), 64'd80);

        // simultaneous fire on two channels
        thresh = 8'd200;
        ev(0, 120, 0);
        ev(2, 120, 0);
        thresh = 8'd100;
        base = int'(spike_count);
        tick();
        chk("dual_spike", 64'(spike[0] & spike[2]), 64'd1);
        chk("dual_count", 64'(spike_count), 64'(base + 2));
        repeat (4) tick();

        // reset during refractory overrides everything
        ev(0, 80, 0);
        ev(1, 120, 0);
        tick();
        tick();
        rst = 1'b1;
        in_valid = 1'b1; in_ch = 3'd0; in_weight = 8'd50;
        tick();
        in_valid = 1'b0;
        chk("rst_membrane", 64'(membrane), 64'd0);
        chk("rst_spike", 64'(spike), 64'd0);
        chk("rst_busy", 64'(refrac_busy), 64'd0);
        chk("rst_count", 64'(spike_count), 64'd0);
        rst = 1'b0;
        ev(1, 30, 0);
        chk("post_rst_event", 64'(membrane[15:8]), 64'd30);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_ch     = 3'($urandom_range(0, 7));
            in_weight = 8'($urandom);
            in_inhib  = ($urandom_range(0, 3) == 0);
            leak_tick = ($urandom_range(0, 3) == 0);
            leak_amt  = 8'($urandom_range(0, 40));
            thresh    = 8'($urandom_range(60, 255));
            v_reset   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 50)) : 8'd0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
